hilo_div_ctrl: RTL

//  Sequencer for the multi-cycle Div unit and owner of the HI/LO registers in the pipeline EX stage.

---
 rtl/hilo_pkg.sv | 24 ++
 rtl/hilo_div_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO and divide sequencer in EX.
package hilo_pkg;

    localparam logic [5:0] F_DIVU = 6'h1B;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;

    localparam int DIV_CYCLES_DEF = 34;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_WB   = 2'd3
    } state_e;

    function automatic logic is_hilo(input logic [5:0] f);
        return (f == F_DIVU) || (f == F_MFHI) || (f == F_MTHI) ||
               (f == F_MFLO) || (f == F_MTLO);
    endfunction

endpackage

// File: rtl/hilo_div_ctrl.sv
// Sequences the multi-cycle divider and owns the architectural HI/LO pair.
module hilo_div_ctrl
    import hilo_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [5:0]  ex_funct,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    output logic        stall,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [63:0] div_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        dvd_q;
    logic [31:0]        dvs_q;

    logic hilo_op;
    logic accept;
    logic acc_divu;
    logic acc_mthi;
    logic acc_mtlo;
    logic acc_mf;

    assign busy     = (state_q != S_IDLE);
    assign hilo_op  = ex_valid & ~ex_flush & is_hilo(ex_funct);
    assign stall    = busy & hilo_op;
    assign accept   = hilo_op & ~stall;
    assign acc_divu = accept & (ex_funct == F_DIVU);
    assign acc_mthi = accept & (ex_funct == F_MTHI);
    assign acc_mtlo = accept & (ex_funct == F_MTLO);
    assign acc_mf   = accept & ((ex_funct == F_MFHI) |
                                (ex_funct == F_MFLO));

    assign mf_valid     = acc_mf;
    assign mf_data      = (ex_funct == F_MFHI) ? hi_q : lo_q;
    assign div_start    = (state_q == S_LOAD);
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign hi           = hi_q;
    assign lo           = lo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (acc_divu && ex_rt != 32'd0) begin
                        dvd_q   <= ex_rs;
                        dvs_q   <= ex_rt;
                        state_q <= S_LOAD;
                    end else if (acc_divu) begin
                        // Divide by zero: result defined without the divider
                        hi_q <= ex_rs;
                        lo_q <= 32'hFFFF_FFFF;
                    end
                    if (acc_mthi) hi_q <= ex_rs;
                    if (acc_mtlo) lo_q <= ex_rs;
                end
                S_LOAD: begin
                    cnt_q   <= CNT_W'(DIV_CYCLES);
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_q <= S_WB;
                end
                S_WB: begin
                    hi_q    <= div_data[63:32];
                    lo_q    <= div_data[31:0];
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
